// File: rtl/foo_port_arbiter.sv
// ----------------------------------------------------------------------------
// foo_port_arbiter
//
// Round-robin arbiter that hands one shared foo_module port bus to one of
// G_NUM_REQ requesters for a whole transaction. A grant is held until the
// owner pulses done, drops req, or the watchdog expires. After a watchdog
// revocation the offending requester is masked until it drops req.
//
// Handshake: req[k] is raised and held for the whole transaction. gnt[k]
// rises one cycle after req[k] wins arbitration. The transaction ends when
// done[k] is seen high for one cycle or req[k] is seen low. After every
// release there is one idle cycle before the next grant.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   req        in   G_NUM_REQ  request per requester
//   done       in   G_NUM_REQ  end-of-transaction pulse per requester
//   gnt        out  G_NUM_REQ  one-hot grant, all-zero when idle (registered)
//   gnt_idx    out  G_IDX_W    index of granted requester, 0 when idle
//   busy       out  high while a grant is active (registered)
//   timeout    out  one-cycle pulse when the watchdog revokes a grant
//   masked     out  G_NUM_REQ  requesters locked out after a timeout
//   fsm_state  out  debug view of the FSM: 0 = IDLE, 1 = BUSY
// ----------------------------------------------------------------------------
module foo_port_arbiter #(
    parameter int  G_NUM_REQ = 4,
    parameter int  G_TIMEOUT = 256,
    localparam int G_IDX_W   = $clog2(G_NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [G_NUM_REQ-1:0] req,
    input  logic [G_NUM_REQ-1:0] done,
    output logic [G_NUM_REQ-1:0] gnt,
    output logic [G_IDX_W-1:0]   gnt_idx,
    output logic                 busy,
    output logic                 timeout,
    output logic [G_NUM_REQ-1:0] masked,
    output logic                 fsm_state
);

    // The watchdog counter needs at least one bit even when disabled.
    localparam int WD_W = (G_TIMEOUT == 0) ? 1 : $clog2(G_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((G_TIMEOUT == 0) ? 0 : G_TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_MAX  = {WD_W{1'b1}};
    localparam logic [G_IDX_W-1:0] IDX_LAST = G_IDX_W'(G_NUM_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state, state_n;
    logic [G_NUM_REQ-1:0] gnt_n, masked_n, eligible;
    logic [G_IDX_W-1:0]   gnt_idx_n, rr_ptr, rr_ptr_n, winner, cand;
    logic [G_IDX_W:0]     sum;
    logic [WD_W-1:0]      wd_cnt, wd_cnt_n;
    logic                 busy_n, timeout_n, found, release_req, expired;

    assign fsm_state = state;
    assign eligible  = req & ~masked;

    always_comb begin
        state_n     = state;
        gnt_n       = gnt;
        gnt_idx_n   = gnt_idx;
        busy_n      = busy;
        timeout_n   = 1'b0;
        rr_ptr_n    = rr_ptr;
        wd_cnt_n    = wd_cnt;
        // A mask bit clears once its requester has been seen with req low.
        masked_n    = masked & req;
        found       = 1'b0;
        winner      = '0;
        sum         = '0;
        cand        = '0;
        release_req = 1'b0;
        expired     = 1'b0;

        // Search eligible requesters starting at rr_ptr, wrapping at G_NUM_REQ.
        for (int i = 0; i < G_NUM_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (G_IDX_W + 1)'(i);
            if (sum >= (G_IDX_W + 1)'(G_NUM_REQ)) begin
                sum = sum - (G_IDX_W + 1)'(G_NUM_REQ);
            end
            cand = sum[G_IDX_W-1:0];
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    state_n        = BUSY;
                    gnt_n          = '0;
                    gnt_n[winner]  = 1'b1;
                    gnt_idx_n      = winner;
                    busy_n         = 1'b1;
                    wd_cnt_n       = '0;
                end
            end
            BUSY: begin
                release_req = done[gnt_idx] | ~req[gnt_idx];
                expired     = (G_TIMEOUT != 0) && (wd_cnt == WD_LAST);
                if (release_req || expired) begin
                    state_n   = IDLE;
                    gnt_n     = '0;
                    gnt_idx_n = '0;
                    busy_n    = 1'b0;
                    rr_ptr_n  = (gnt_idx == IDX_LAST) ? '0 : gnt_idx + G_IDX_W'(1);
                    // A regular end of transaction wins over a coincident expiry.
                    if (expired && !release_req) begin
                        timeout_n         = 1'b1;
                        masked_n[gnt_idx] = 1'b1;
                    end
                end else if (wd_cnt != WD_MAX) begin
                    wd_cnt_n = wd_cnt + WD_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
            masked  <= '0;
            rr_ptr  <= '0;
            wd_cnt  <= '0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            gnt_idx <= gnt_idx_n;
            busy    <= busy_n;
            timeout <= timeout_n;
            masked  <= masked_n;
            rr_ptr  <= rr_ptr_n;
            wd_cnt  <= wd_cnt_n;
        end
    end

endmodule

// File: tb/tb_foo_port_arbiter.sv
module tb_foo_port_arbiter;
    localparam int N  = 4;
    localparam int T  = 8;
    localparam int IW = 2;
    localparam int VW = N + IW + 1 + 1 + N;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  done = '0;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          busy;
    logic          timeout;
    logic [N-1:0]  masked;
    logic          fsm_state;

    int checks = 0;
    int failures = 0;

    // Reference model: who owns the bus, how long it has held it,
    // round-robin start point and the lockout set.
    int           m_owner = -1;
    int           m_rr = 0;
    int           m_held = 0;
    logic [N-1:0] m_masked = '0;
    logic         m_timeout = 1'b0;

    foo_port_arbiter #(.G_NUM_REQ(N), .G_TIMEOUT(T)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done), .gnt(gnt),
        .gnt_idx(gnt_idx), .busy(busy), .timeout(timeout), .masked(masked),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Advance the model using the inputs currently applied.
    task automatic model_advance();
        logic [N-1:0] mask_next;
        logic         quit, expired;
        int           k;
        m_timeout = 1'b0;
        if (reset) begin
            m_owner = -1; m_rr = 0; m_held = 0; m_masked = '0;
        end else if (m_owner < 0) begin
            mask_next = m_masked & req;
            for (int i = 0; i < N; i++) begin
                k = (m_rr + i) % N;
                if (m_owner < 0 && req[k] && !m_masked[k]) begin
                    m_owner = k;
                    m_held  = 0;
                end
            end
            m_masked = mask_next;
        end else begin
            k = m_owner;
            quit = done[k] || !req[k];
            expired = (m_held == T - 1);
            mask_next = m_masked & req;
            if (quit || expired) begin
                if (expired && !quit) begin
                    m_timeout = 1'b1;
                    mask_next[k] = 1'b1;
                end
                m_rr = (k + 1) % N;
                m_owner = -1;
            end else if (m_held < T) begin
                m_held++;
            end
            m_masked = mask_next;
        end
    endtask

    function automatic logic [VW-1:0] model_vec();
        logic [N-1:0]  g;
        logic [IW-1:0] ix;
        g  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        ix = (m_owner >= 0) ? IW'(m_owner) : '0;
        return {g, ix, (m_owner >= 0), m_timeout, m_masked};
    endfunction

    // One clock: model sees the same inputs as the DUT; sampling is 1 time unit after the edge.
    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = '0; done = '0;
        repeat (3) step();
        checks++;
        if ({gnt, gnt_idx, busy, timeout, masked, fsm_state} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected all zero", {gnt, gnt_idx, busy, timeout, masked, fsm_state});
        end
        reset = 1'b0;
        step();
        checks++;
        if ({gnt, busy} !== '0) begin
            failures++;
            $display("FAIL reset_idle: gnt=%b busy=%b expected 0", gnt, busy);
        end
    endtask

    task automatic test_single();
        req = 4'b0001;
        step();
        checks++;
        if ({gnt, gnt_idx, busy} !== {4'b0001, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL single_grant: gnt=%b idx=%0d busy=%b expected 0001/0/1", gnt, gnt_idx, busy);
        end
        step(); step();
        done = 4'b0001;
        step();
        done = '0; req = '0;
        checks++;
        if ({gnt, busy} !== '0) begin
            failures++;
            $display("FAIL single_release: gnt=%b busy=%b expected 0", gnt, busy);
        end
        step();
    endtask

    task automatic test_round_robin();
        int order[5] = '{0, 1, 2, 3, 0};
        reset = 1'b1; step(); reset = 1'b0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            step();
            checks++;
            if (gnt !== N'(1 << order[g]) || gnt_idx !== IW'(order[g])) begin
                failures++;
                $display("FAIL rr_order[%0d]: gnt=%b idx=%0d expected idx %0d", g, gnt, gnt_idx, order[g]);
            end
            step();
            done = N'(1 << order[g]);
            step();
            done = '0;
            checks++;
            if (gnt !== '0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rr_bubble[%0d]: gnt=%b busy=%b expected idle", g, gnt, busy);
            end
        end
        req = '0;
        step();
    endtask

    task automatic test_wrap();
        reset = 1'b1; step(); reset = 1'b0;
        req = 4'b0100;
        step();
        done = 4'b0100; req = 4'b0011;
        step();
        done = '0;
        step();
        checks++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
            failures++;
            $display("FAIL wrap_grant: gnt=%b idx=%0d expected 0001/0", gnt, gnt_idx);
        end
        done = 4'b0001;
        step();
        done = '0;
        step();
        checks++;
        if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
            failures++;
            $display("FAIL wrap_next: gnt=%b idx=%0d expected 0010/1", gnt, gnt_idx);
        end
        req = '0;
        step();
    endtask

    task automatic test_timeout();
        reset = 1'b1; step(); reset = 1'b0;
        req = 4'b0010;
        step();
        for (int c = 0; c < T - 1; c++) begin
            step();
            checks++;
            if (gnt !== 4'b0010 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL wd_hold[%0d]: gnt=%b timeout=%b expected 0010/0", c, gnt, timeout);
            end
        end
        step();
        checks++;
        if ({gnt, busy, timeout, masked} !== {4'b0000, 1'b0, 1'b1, 4'b0010}) begin
            failures++;
            $display("FAIL wd_expire: gnt=%b busy=%b timeout=%b masked=%b expected 0000/0/1/0010", gnt, busy, timeout, masked);
        end
        req = 4'b0011;
        for (int r = 0; r < 3; r++) begin
            step();
            checks++;
            if (gnt !== 4'b0001 || timeout !== 1'b0 || masked !== 4'b0010) begin
                failures++;
                $display("FAIL wd_locked[%0d]: gnt=%b timeout=%b masked=%b expected 0001/0/0010", r, gnt, timeout, masked);
            end
            done = 4'b0001;
            step();
            done = '0;
        end
        req = 4'b0001;
        step();
        checks++;
        if (masked !== 4'b0000) begin
            failures++;
            $display("FAIL wd_unmask: masked=%b expected 0000", masked);
        end
        req = 4'b0010;
        step();
        step();
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL wd_regrant: gnt=%b expected 0010", gnt);
        end
        req = '0;
        step();
    endtask

    task automatic test_done_at_expiry();
        reset = 1'b1; step(); reset = 1'b0;
        req = 4'b0100;
        step();
        repeat (T - 1) step();
        done = 4'b0100;
        step();
        done = '0; req = '0;
        checks++;
        if ({gnt, busy, timeout, masked} !== '0) begin
            failures++;
            $display("FAIL done_at_expiry: gnt=%b busy=%b timeout=%b masked=%b expected all 0", gnt, busy, timeout, masked);
        end
        step();
    endtask

    task automatic test_reset_mid_busy();
        reset = 1'b1; step(); reset = 1'b0;
        req = 4'b0001;
        step();
        repeat (3) step();
        reset = 1'b1;
        step();
        checks++;
        if ({gnt, busy, timeout, fsm_state} !== '0) begin
            failures++;
            $display("FAIL reset_mid_busy: gnt=%b busy=%b timeout=%b state=%b expected 0", gnt, busy, timeout, fsm_state);
        end
        reset = 1'b0; req = 4'b1000;
        step();
        checks++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
            failures++;
            $display("FAIL reset_regrant: gnt=%b idx=%0d expected 1000/3", gnt, gnt_idx);
        end
        req = '0;
        step();
    endtask

    task automatic test_random();
        int to_seen = 0;
        reset = 1'b1; req = '0; done = '0;
        step();
        reset = 1'b0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                end
                done[i] = req[i] && ($urandom_range(0, 13) == 0);
            end
            if ($urandom_range(0, 199) == 0) reset = 1'b1;
            step();
            reset = 1'b0;
            if (timeout) to_seen++;
            checks++;
            if ({gnt, gnt_idx, busy, timeout, masked} !== model_vec()) begin
                failures++;
                $display("FAIL random_cycle[%0d]: dut=%b model=%b (gnt,idx,busy,timeout,masked)", c, {gnt, gnt_idx, busy, timeout, masked}, model_vec());
            end
            checks++;
            if (!$onehot0(gnt) || busy !== (|gnt) || gnt[gnt_idx] !== busy || (timeout && busy) || fsm_state !== busy) begin
                failures++;
                $display("FAIL random_invariant[%0d]: gnt=%b idx=%0d busy=%b timeout=%b state=%b", c, gnt, gnt_idx, busy, timeout, fsm_state);
            end
        end
        req = '0; done = '0;
        step(); step();
        checks++;
        if (to_seen == 0) begin
            failures++;
            $display("FAIL random_timeouts: got %0d watchdog pulses, required at least 1", to_seen);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_timeout();
        test_done_at_expiry();
        test_reset_mid_busy();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
